// File: rtl/decode_stage.sv
// Registered instruction decoder with a 2-entry skid buffer between fetch and execute.
// Instructions are decoded on entry, so OUT and SKID hold finished control bundles.
module decode_stage #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int TRAP_ILLEGAL   = 1,
    localparam int INSTR_WIDTH   = 4 + 3 * REG_ADDR_WIDTH,
    localparam int IMM_WIDTH     = 2 * REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rd_address,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rs_address,
    output logic [REG_ADDR_WIDTH-1:0] decoded_rt_address,
    output logic [2:0]                decoded_nzp,
    output logic [IMM_WIDTH-1:0]      decoded_immediate,
    output logic                      decoded_reg_write_enable,
    output logic                      decoded_mem_read_enable,
    output logic                      decoded_mem_write_enable,
    output logic                      decoded_nzp_write_enable,
    output logic [1:0]                decoded_reg_input_mux,
    output logic [1:0]                decoded_alu_arithmetic_mux,
    output logic                      decoded_alu_output_mux,
    output logic                      decoded_pc_mux,
    output logic                      decoded_done,
    output logic                      decoded_illegal,
    output logic                      illegal_seen,
    output logic [COUNT_WIDTH-1:0]    decoded_count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [2:0]                nzp;
        logic [IMM_WIDTH-1:0]      imm;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      nzp_write;
        logic [1:0]                reg_input_mux;
        logic [1:0]                alu_arith_mux;
        logic                      alu_output_mux;
        logic                      pc_mux;
        logic                      done;
        logic                      illegal;
    } bundle_t;

    bundle_t    in_decoded;
    bundle_t    out_q, out_next, skid_q, skid_next, out_view;
    logic       out_valid_q, out_valid_next, skid_valid_q, skid_valid_next;
    logic [3:0] opcode;
    logic       in_fire, out_fire, out_space;

    assign opcode    = instruction[INSTR_WIDTH-1 -: 4];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_space = !out_valid_q || out_ready;

    // Opcodes A-E fall into the default arm; enables stay 0 either way.
    always_comb begin
        in_decoded     = '0;
        in_decoded.rd  = instruction[INSTR_WIDTH-5 -: REG_ADDR_WIDTH];
        in_decoded.rs  = instruction[INSTR_WIDTH-5-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
        in_decoded.rt  = instruction[REG_ADDR_WIDTH-1:0];
        in_decoded.nzp = instruction[INSTR_WIDTH-5 -: 3];
        in_decoded.imm = instruction[IMM_WIDTH-1:0];
        case (opcode)
            4'h0: ;
            4'h1: in_decoded.pc_mux = 1'b1;
            4'h2: begin
                in_decoded.nzp_write      = 1'b1;
                in_decoded.alu_output_mux = 1'b1;
            end
            4'h3: in_decoded.reg_write = 1'b1;
            4'h4: begin
                in_decoded.reg_write     = 1'b1;
                in_decoded.alu_arith_mux = 2'b01;
            end
            4'h5: begin
                in_decoded.reg_write     = 1'b1;
                in_decoded.alu_arith_mux = 2'b10;
            end
            4'h6: begin
                in_decoded.reg_write     = 1'b1;
                in_decoded.alu_arith_mux = 2'b11;
            end
            4'h7: in_decoded.mem_read = 1'b1;
            4'h8: in_decoded.mem_write = 1'b1;
            4'h9: begin
                in_decoded.reg_write     = 1'b1;
                in_decoded.reg_input_mux = 2'b10;
            end
            4'hF: in_decoded.done = 1'b1;
            default: in_decoded.illegal = (TRAP_ILLEGAL != 0);
        endcase
    end

    // SKID only fills while OUT is stalled, so it always drains into OUT before new input.
    always_comb begin
        out_next        = out_q;
        out_valid_next  = out_valid_q;
        skid_next       = skid_q;
        skid_valid_next = skid_valid_q;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_space) begin
            if (skid_valid_q) begin
                out_next        = skid_q;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                out_next       = in_decoded;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_next       = in_decoded;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q         <= '0;
            skid_q        <= '0;
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            in_ready      <= 1'b0;
            illegal_seen  <= 1'b0;
            decoded_count <= '0;
        end else begin
            out_q        <= out_next;
            skid_q       <= skid_next;
            out_valid_q  <= out_valid_next;
            skid_valid_q <= skid_valid_next;
            in_ready     <= !skid_valid_next;
            if (out_fire) begin
                decoded_count <= decoded_count + COUNT_ONE;
                if (out_q.illegal) begin
                    illegal_seen <= 1'b1;
                end
            end
        end
    end

    // OUT keeps stale contents after draining; mask them so an empty stage shows zeros.
    assign out_view = out_valid_q ? out_q : '0;

    assign out_valid                  = out_valid_q;
    assign decoded_rd_address         = out_view.rd;
    assign decoded_rs_address         = out_view.rs;
    assign decoded_rt_address         = out_view.rt;
    assign decoded_nzp                = out_view.nzp;
    assign decoded_immediate          = out_view.imm;
    assign decoded_reg_write_enable   = out_view.reg_write;
    assign decoded_mem_read_enable    = out_view.mem_read;
    assign decoded_mem_write_enable   = out_view.mem_write;
    assign decoded_nzp_write_enable   = out_view.nzp_write;
    assign decoded_reg_input_mux      = out_view.reg_input_mux;
    assign decoded_alu_arithmetic_mux = out_view.alu_arith_mux;
    assign decoded_alu_output_mux     = out_view.alu_output_mux;
    assign decoded_pc_mux             = out_view.pc_mux;
    assign decoded_done               = out_view.done;
    assign decoded_illegal            = out_view.illegal;

endmodule
